// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared widths and types for the decode stage.
//   dq_entry_t - one buffered instruction (pc, raw instr, decoded ctl, imm)
//   fwd_src_t  - one forwarding source (valid, pending, dst, data)
// The data widths live here, not as module parameters, because the
// packed structs are sized by them.
package decode_queue_pkg;
  localparam int DQ_XLEN    = 64;
  localparam int DQ_CTL_W   = 32;
  localparam int DQ_DEPTH   = 4;
  localparam int DQ_NUM_FWD = 3;
  localparam int DQ_PTR_W   = $clog2(DQ_DEPTH);

  typedef struct packed {
    logic [DQ_XLEN-1:0]  pc;
    logic [31:0]         instr;
    logic [DQ_CTL_W-1:0] ctl;
    logic [DQ_XLEN-1:0]  imm;
  } dq_entry_t;

  typedef struct packed {
    logic               valid;
    logic               pending;
    logic [4:0]         dst;
    logic [DQ_XLEN-1:0] data;
  } fwd_src_t;
endpackage

// File: rtl/decode_queue_fwd.sv
// operand_fwd_mux: resolves one source operand.
//   i_rs          - architectural source register
//   i_rd          - regfile read data for i_rs
//   i_src         - forwarding sources, index 0 = youngest = highest priority
//   o_data        - resolved operand (x0 always reads zero)
//   o_hit_pending - the winning source has no result yet (load-use hazard)
module operand_fwd_mux
  import decode_queue_pkg::*;
#(
  parameter int NUM_FWD = DQ_NUM_FWD
) (
  input  logic [4:0]               i_rs,
  input  logic [DQ_XLEN-1:0]       i_rd,
  input  fwd_src_t [NUM_FWD-1:0]   i_src,
  output logic [DQ_XLEN-1:0]       o_data,
  output logic                     o_hit_pending
);
  // Walk from lowest to highest priority so the youngest match is the last
  // write; an older pending match is therefore masked by a younger hit.
  always_comb begin
    o_data        = i_rd;
    o_hit_pending = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_src[i].valid && (i_src[i].dst == i_rs)) begin
        o_data        = i_src[i].data;
        o_hit_pending = i_src[i].pending;
      end
    end
    if (i_rs == 5'd0) begin
      o_data        = '0;
      o_hit_pending = 1'b0;
    end
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO between fetch and execute with
// a registered ID/EX output stage.
//   clk/reset/flush         - clock, sync active-high reset, pipeline kill
//   in_*                    - fetch side (valid/ready) plus decoded fields
//   rs1_addr/rs2_addr, rd*  - combinational regfile read for the head entry
//   fwd_*                   - NUM_FWD forwarding sources, index 0 highest priority
//   out_*                   - execute side (valid/ready) plus resolved operands
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH   = DQ_DEPTH,
  parameter int NUM_FWD = DQ_NUM_FWD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DQ_XLEN-1:0]        in_pc,
  input  logic [31:0]               in_instr,
  input  logic [DQ_CTL_W-1:0]       in_ctl,
  input  logic [DQ_XLEN-1:0]        in_imm,
  output logic [4:0]                rs1_addr,
  output logic [4:0]                rs2_addr,
  input  logic [DQ_XLEN-1:0]        rd1,
  input  logic [DQ_XLEN-1:0]        rd2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*5-1:0]      fwd_dst,
  input  logic [NUM_FWD*DQ_XLEN-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DQ_XLEN-1:0]        out_pc,
  output logic [31:0]               out_instr,
  output logic [DQ_CTL_W-1:0]       out_ctl,
  output logic [DQ_XLEN-1:0]        out_imm,
  output logic [DQ_XLEN-1:0]        out_srca,
  output logic [DQ_XLEN-1:0]        out_srcb,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_dst,
  output logic [11:0]               out_csr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_out_valid;
  dq_entry_t          r_out;
  logic [DQ_XLEN-1:0] r_srca, r_srcb;

  dq_entry_t             w_head;
  fwd_src_t [NUM_FWD-1:0] w_src;
  logic [DQ_XLEN-1:0]    w_op1, w_op2;
  logic                  w_pend1, w_pend2;
  logic                  w_head_valid, w_push, w_issue;

  genvar g;
  generate
    for (g = 0; g < NUM_FWD; g++) begin : g_src
      assign w_src[g].valid   = fwd_valid[g];
      assign w_src[g].pending = fwd_pending[g];
      assign w_src[g].dst     = fwd_dst[g*5 +: 5];
      assign w_src[g].data    = fwd_data[g*DQ_XLEN +: DQ_XLEN];
    end
  endgenerate

  assign w_head   = r_mem[r_head];
  assign rs1_addr = w_head.instr[19:15];
  assign rs2_addr = w_head.instr[24:20];

  operand_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd1 (
    .i_rs(rs1_addr), .i_rd(rd1), .i_src(w_src), .o_data(w_op1), .o_hit_pending(w_pend1)
  );
  operand_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd2 (
    .i_rs(rs2_addr), .i_rd(rd2), .i_src(w_src), .o_data(w_op2), .o_hit_pending(w_pend2)
  );

  // Full blocks push even if the head issues this cycle (no push-through-pop).
  assign in_ready     = (r_count != CNT_W'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_push       = in_valid && in_ready && !flush;
  assign w_issue      = w_head_valid && !w_pend1 && !w_pend2 &&
                        (!r_out_valid || out_ready) && !flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{pc: in_pc, instr: in_instr, ctl: in_ctl, imm: in_imm};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_issue) r_head <= r_head + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ID/EX register: operands are captured only on the issue edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_srca      <= '0;
      r_srcb      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out       <= w_head;
      r_srca      <= w_op1;
      r_srcb      <= w_op2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out.pc;
  assign out_instr = r_out.instr;
  assign out_ctl   = r_out.ctl;
  assign out_imm   = r_out.imm;
  assign out_srca  = r_srca;
  assign out_srcb  = r_srcb;
  assign out_rs1   = r_out.instr[19:15];
  assign out_rs2   = r_out.instr[24:20];
  assign out_dst   = r_out.instr[11:7];
  assign out_csr   = r_out.instr[31:20];
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int NF    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [63:0] in_pc = '0, in_imm = '0;
  logic [31:0] in_instr = '0, in_ctl = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rd1, rd2;
  logic [NF-1:0]    fwd_valid = '0, fwd_pending = '0;
  logic [NF*5-1:0]  fwd_dst = '0;
  logic [NF*64-1:0] fwd_data = '0;
  logic [63:0] out_pc, out_imm, out_srca, out_srcb;
  logic [31:0] out_instr, out_ctl;
  logic [4:0]  out_rs1, out_rs2, out_dst;
  logic [11:0] out_csr;

  logic [63:0] rf [32];
  assign rd1 = rf[rs1_addr];
  assign rd2 = rf[rs2_addr];

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .NUM_FWD(NF)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_ctl(in_ctl), .in_imm(in_imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1), .rd2(rd2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_ctl(out_ctl), .out_imm(out_imm), .out_srca(out_srca), .out_srcb(out_srcb),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_dst(out_dst), .out_csr(out_csr)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [31:0] ctl;
    logic [63:0] imm;
  } ent_t;

  ent_t        q[$];
  logic        m_valid = 1'b0;
  ent_t        m_out = '{default: 0};
  logic [63:0] m_a = '0, m_b = '0;
  bit          started = 0, track = 0;
  logic [63:0] obs[$];

  // Operand rule: x0 reads zero, else youngest matching source, else regfile.
  function automatic logic [63:0] resolve(input logic [4:0] rs, output logic pend);
    pend = 1'b0;
    if (rs == 5'd0) return 64'd0;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_dst[i*5 +: 5] == rs) begin
        pend = fwd_pending[i];
        return fwd_data[i*64 +: 64];
      end
    return rf[rs];
  endfunction

  always @(negedge clk) begin : compare
    logic p1, p2, iss, psh;
    logic [63:0] a, b;
    if (started) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("out_pc", out_pc, m_out.pc);
        chk("out_instr", {32'd0, out_instr}, {32'd0, m_out.instr});
        chk("out_ctl", {32'd0, out_ctl}, {32'd0, m_out.ctl});
        chk("out_imm", out_imm, m_out.imm);
        chk("out_srca", out_srca, m_a);
        chk("out_srcb", out_srcb, m_b);
        chk("out_rs1", {59'd0, out_rs1}, {59'd0, m_out.instr[19:15]});
        chk("out_rs2", {59'd0, out_rs2}, {59'd0, m_out.instr[24:20]});
        chk("out_dst", {59'd0, out_dst}, {59'd0, m_out.instr[11:7]});
        chk("out_csr", {52'd0, out_csr}, {52'd0, m_out.instr[31:20]});
        if (track && out_ready) obs.push_back(out_pc);
      end
      if (q.size() > 0) begin
        chk("rs1_addr", {59'd0, rs1_addr}, {59'd0, q[0].instr[19:15]});
        chk("rs2_addr", {59'd0, rs2_addr}, {59'd0, q[0].instr[24:20]});
      end
    end
    // advance the model to the state after the coming posedge
    if (reset) begin
      q.delete(); m_valid = 1'b0; m_out = '{default: 0}; m_a = '0; m_b = '0;
    end else if (flush) begin
      q.delete(); m_valid = 1'b0;
    end else begin
      psh = in_valid && (q.size() < DEPTH);
      iss = 1'b0;
      if (q.size() > 0) begin
        a = resolve(q[0].instr[19:15], p1);
        b = resolve(q[0].instr[24:20], p2);
        iss = !p1 && !p2 && (!m_valid || out_ready);
      end
      if (iss) begin
        m_out = q[0]; m_a = a; m_b = b; m_valid = 1'b1;
        void'(q.pop_front());
      end else if (out_ready) m_valid = 1'b0;
      if (psh) q.push_back('{in_pc, in_instr, in_ctl, in_imm});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = {7'h21, r2, r1, 3'b000, rd, 7'h33};
    in_ctl   = pc[31:0] ^ 32'h5a5a_0f0f;
    in_imm   = ~pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
    rf[0] = 64'hDEAD;
    tick();
    started = 1;
    tick();
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst out_pc", out_pc, 64'd0);
    chk("rst out_srca", out_srca, 64'd0);
    chk("rst out_instr", {32'd0, out_instr}, 64'd0);
    reset = 1'b0;

    // in-order flow, 2-cycle in-to-out latency
    out_ready = 1'b1;
    drive(64'h8000_0000, 1, 2, 3); tick();
    chk("lat t", {63'd0, out_valid}, 64'd0);
    drive(64'h8000_0004, 2, 3, 4); tick();
    chk("lat t+1 valid", {63'd0, out_valid}, 64'd1);
    chk("first pc", out_pc, 64'h8000_0000);
    chk("first srca", out_srca, 64'h1001);
    chk("first srcb", out_srcb, 64'h1002);
    drive(64'h8000_0008, 3, 1, 5); tick();
    chk("second pc", out_pc, 64'h8000_0004);
    in_valid = 1'b0; tick();
    chk("third pc", out_pc, 64'h8000_0008);
    tick();
    chk("drained", {63'd0, out_valid}, 64'd0);

    // fill with execute stalled; the ID/EX register takes the first instr
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(64'h9000_0000 + 64'(4 * k), 5'(k + 1), 5'(k + 2), 5'd1); tick();
    end
    chk("full in_ready", {63'd0, in_ready}, 64'd0);
    chk("stalled pc", out_pc, 64'h9000_0000);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("drain pc1", out_pc, 64'h9000_0004);
    repeat (6) tick();

    // forwarding priority and x0
    rf[5] = 64'hCC;
    fwd_valid = 3'b111;
    fwd_dst   = {5'd5, 5'd0, 5'd5};
    fwd_data  = {64'hBB, 64'h11, 64'hAA};
    drive(64'hA000_0000, 5, 0, 7); tick();
    drive(64'hA000_0004, 0, 5, 8); tick();
    chk("fwd srca", out_srca, 64'hAA);
    chk("x0 srcb", out_srcb, 64'd0);
    in_valid = 1'b0; tick();
    chk("x0 srca", out_srca, 64'd0);
    chk("fwd srcb", out_srcb, 64'hAA);
    tick();

    // load-use hazard on rs2
    fwd_valid = 3'b001; fwd_pending = 3'b001;
    fwd_dst = {5'd0, 5'd0, 5'd6}; fwd_data = {64'd0, 64'd0, 64'h99};
    drive(64'hB000_0000, 1, 6, 9); tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("hazard stall", {63'd0, out_valid}, 64'd0);
    fwd_pending = 3'b000; fwd_data = {64'd0, 64'd0, 64'h42}; tick();
    chk("hazard issue", {63'd0, out_valid}, 64'd1);
    chk("hazard srcb", out_srcb, 64'h42);
    fwd_valid = '0; tick();

    // flush with three queued plus a valid output, and in_valid high
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(64'hC000_0000 + 64'(4 * k), 1, 2, 3); tick();
    end
    drive(64'hC000_0010, 1, 2, 3); flush = 1'b1; tick();
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("flush lost", {63'd0, out_valid}, 64'd0);

    // pointer wrap with mixed stalls
    begin
      int pushed = 0;
      bit acc;
      track = 1;
      for (int c = 0; c < 40; c++) begin
        if (pushed < 10 && (c % 3 != 2)) drive(64'hD000_0000 + 64'(4 * pushed), 5'(c % 7), 5'(c % 5), 5'd2);
        else in_valid = 1'b0;
        out_ready = (c % 4 < 2);
        acc = in_valid && in_ready;
        tick();
        if (acc) pushed++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
      track = 0;
      chk("wrap pushed", 64'(pushed), 64'd10);
      chk("wrap issued", 64'(obs.size()), 64'd10);
      for (int i = 0; i < 10 && i < obs.size(); i++) chk("wrap pc", obs[i], 64'hD000_0000 + 64'(4 * i));
    end

    // reset mid-stream dominates flush and push
    out_ready = 1'b0;
    drive(64'hE000_0000, 1, 2, 3); tick();
    drive(64'hE000_0004, 1, 2, 3); tick();
    reset = 1'b1; flush = 1'b1; tick();
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst out_pc", out_pc, 64'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
